// File: rtl/rbm_frame_driver.sv
// rbm_frame_driver
// Host-side sequencer for the RBM top level. Collects one input frame of
// input_dim words from a valid/ready stream into the flat InputDataPort,
// pulses the RBM reset, holds data_valid until a fresh rising edge of
// finish, captures OutputDataPort and streams the result words back out.
//
// Ports
//   clock, reset          rising-edge clock, async active-low reset
//   in_data/in_valid/in_ready      input word stream (accepted in LOAD)
//   rbm_reset, data_valid          control toward Main
//   InputDataPort                  packed frame, word i at [i*bitlength +: bitlength]
//   OutputDataPort, finish         packed result and completion level from Main
//   out_data/out_valid/out_ready/out_last   result word stream
//   busy                           high in any state other than LOAD
//   err                            sticky timeout flag, cleared only by reset
//
// state  | meaning
// -------+---------------------------------------------------------------
// LOAD   | accept input words into the frame buffer
// RST    | hold rbm_reset high for rst_cycles cycles
// GAP    | single quiet cycle between RBM reset and data_valid
// RUN    | data_valid high, wait for a new finish edge or timeout
// UNLOAD | stream the captured result words out
module rbm_frame_driver #(
  parameter int bitlength      = 12,
  parameter int input_dim      = 15,
  parameter int output_dim     = 2,
  parameter int rst_cycles     = 2,
  parameter int timeout_cycles = 4096
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [bitlength-1:0]              in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              rbm_reset,
  output logic                              data_valid,
  output logic [input_dim*bitlength-1:0]    InputDataPort,
  input  logic [output_dim*bitlength-1:0]   OutputDataPort,
  input  logic                              finish,
  output logic [bitlength-1:0]              out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              err
);

  localparam int WW = (input_dim > 1)      ? $clog2(input_dim)      : 1;
  localparam int RW = (rst_cycles > 1)     ? $clog2(rst_cycles)     : 1;
  localparam int TW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam int OW = (output_dim > 1)     ? $clog2(output_dim)     : 1;

  localparam logic [WW-1:0] W_LAST = WW'(input_dim - 1);
  localparam logic [RW-1:0] R_LOAD = RW'(rst_cycles - 1);
  localparam logic [TW-1:0] T_LAST = TW'(timeout_cycles - 1);
  localparam logic [OW-1:0] O_LAST = OW'(output_dim - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_RST,
    S_GAP,
    S_RUN,
    S_UNLOAD
  } state_t;

  state_t state, next_state;

  logic [WW-1:0] wcnt;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] tcnt;
  logic [OW-1:0] ocnt;
  logic          finish_q;

  logic [input_dim*bitlength-1:0]  fbuf;
  logic [output_dim*bitlength-1:0] rbuf;

  logic accept;
  logic capture;
  logic timeout;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_LOAD;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    in_ready   = 1'b0;
    rbm_reset  = 1'b0;
    data_valid = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    busy       = 1'b1;
    case (state)
      S_LOAD: begin
        // in_ready follows the async reset so it reads 0 while reset is held
        in_ready = reset;
        busy     = 1'b0;
        if (in_valid) begin
          accept = 1'b1;
          if (wcnt == W_LAST) next_state = S_RST;
        end
      end
      S_RST: begin
        rbm_reset = 1'b1;
        if (rcnt == '0) next_state = S_GAP;
      end
      S_GAP: begin
        next_state = S_RUN;
      end
      S_RUN: begin
        data_valid = 1'b1;
        // A finish level carried into RUN leaves finish_q high, so only a
        // new rising edge can capture. Capture wins over a same-cycle timeout.
        if (finish && !finish_q) begin
          capture    = 1'b1;
          next_state = S_UNLOAD;
        end else if (tcnt == T_LAST) begin
          timeout    = 1'b1;
          next_state = S_LOAD;
        end
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = rbuf[ocnt*bitlength +: bitlength];
        out_last  = (ocnt == O_LAST);
        if (out_ready && (ocnt == O_LAST)) next_state = S_LOAD;
      end
      default: begin
        next_state = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt     <= '0;
      rcnt     <= '0;
      tcnt     <= '0;
      ocnt     <= '0;
      finish_q <= 1'b0;
      fbuf     <= '0;
      rbuf     <= '0;
      err      <= 1'b0;
    end else begin
      finish_q <= finish;

      if (accept) begin
        fbuf[wcnt*bitlength +: bitlength] <= in_data;
        if (wcnt == W_LAST) begin
          wcnt <= '0;
          rcnt <= R_LOAD;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      // rcnt counts down to its terminal value of zero
      if (state == S_RST && rcnt != '0) rcnt <= rcnt - 1'b1;

      if (state == S_GAP) tcnt <= '0;
      if (state == S_RUN && !capture && !timeout) tcnt <= tcnt + 1'b1;

      if (capture) rbuf <= OutputDataPort;
      if (timeout) err <= 1'b1;

      if (state == S_UNLOAD && out_ready) begin
        if (ocnt == O_LAST) ocnt <= '0;
        else                ocnt <= ocnt + 1'b1;
      end
    end
  end

  assign InputDataPort = fbuf;

endmodule

// File: tb/tb_rbm_frame_driver.sv
// Self-checking bench for rbm_frame_driver: directed frames plus randomized
// words, run lengths and consumer stalls, checked against a frame-level model.
module tb_rbm_frame_driver;

  localparam int BL   = 12;
  localparam int IND  = 15;
  localparam int OUTD = 2;
  localparam int RSTC = 2;
  localparam int TOC  = 64;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [BL-1:0]        in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 rbm_reset;
  logic                 data_valid;
  logic [IND*BL-1:0]    InputDataPort;
  logic [OUTD*BL-1:0]   OutputDataPort;
  logic                 finish;
  logic [BL-1:0]        out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 err;

  int checks = 0;
  int errors = 0;

  logic [BL-1:0] frame_w [IND];
  logic [BL-1:0] res_w   [OUTD];

  rbm_frame_driver #(
    .bitlength(BL), .input_dim(IND), .output_dim(OUTD),
    .rst_cycles(RSTC), .timeout_cycles(TOC)
  ) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rbm_reset(rbm_reset), .data_valid(data_valid),
    .InputDataPort(InputDataPort), .OutputDataPort(OutputDataPort),
    .finish(finish),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Expected packed frame: word i contributes value * 2^(i*BL)
  function automatic logic [IND*BL-1:0] model_frame();
    logic [IND*BL-1:0] p = '0;
    for (int i = 0; i < IND; i++) p = p | ((IND*BL)'(frame_w[i]) << (i*BL));
    return p;
  endfunction

  function automatic logic [OUTD*BL-1:0] model_result();
    logic [OUTD*BL-1:0] p = '0;
    for (int i = 0; i < OUTD; i++) p = p | ((OUTD*BL)'(res_w[i]) << (i*BL));
    return p;
  endfunction

  task automatic rand_frame();
    for (int i = 0; i < IND; i++) frame_w[i] = BL'($urandom);
  endtask

  task automatic rand_result();
    for (int i = 0; i < OUTD; i++) res_w[i] = BL'($urandom);
  endtask

  task automatic load_frame(input bit gaps);
    for (int i = 0; i < IND; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = BL'($urandom);
          chk("in_ready_idle", in_ready, 1);
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = frame_w[i];
      chk("in_ready_load", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    in_data  = BL'($urandom);
    chk("packed_frame", InputDataPort, model_frame());
  endtask

  // Called at the first cycle after the last word; returns in RUN cycle 0.
  task automatic start_seq();
    for (int k = 0; k < RSTC; k++) begin
      chk("rst_high", rbm_reset, 1);
      chk("rst_dv", data_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 1);
      tick();
    end
    chk("gap_rst", rbm_reset, 0);
    chk("gap_dv", data_valid, 0);
    chk("gap_busy", busy, 1);
    tick();
    chk("run_dv", data_valid, 1);
    chk("run_rst", rbm_reset, 0);
    chk("run_frame_stable", InputDataPort, model_frame());
  endtask

  // finish pulses high during RUN cycle k-1; result expected the next cycle.
  task automatic run_pulse(input int k);
    OutputDataPort = model_result();
    for (int j = 0; j < k; j++) begin
      chk("run_dv_hold", data_valid, 1);
      chk("run_no_out", out_valid, 0);
      finish = (j == k - 1);
      tick();
    end
    finish = 1'b0;
    OutputDataPort = ~model_result();
  endtask

  task automatic unload(input int stall_n, input bit rnd, input int exp_cycles);
    logic [BL-1:0] q[$];
    int   cycles = 0;
    int   stall  = stall_n;
    logic rdy;
    for (int i = 0; i < OUTD; i++) q.push_back(res_w[i]);
    while (q.size() > 0 && cycles < 50) begin
      if (stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, q[0]);
      chk("out_last", out_last, (q.size() == 1));
      chk("unload_dv", data_valid, 0);
      out_ready = rdy;
      tick();
      if (rdy) void'(q.pop_front());
      cycles++;
    end
    out_ready = 1'b0;
    chk("unload_drained", q.size(), 0);
    if (exp_cycles > 0) chk("unload_cycles", cycles, exp_cycles);
    chk("back_in_ready", in_ready, 1);
    chk("back_out_valid", out_valid, 0);
    chk("back_busy", busy, 0);
  endtask

  initial begin
    reset          = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    finish         = 1'b0;
    out_ready      = 1'b0;
    OutputDataPort = '0;

    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rbm_reset", rbm_reset, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_input_port", InputDataPort, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Frame 1: words 1..15, result {0x0AB,0x123}, back-to-back unload
    for (int i = 0; i < IND; i++) frame_w[i] = BL'(i + 1);
    res_w[0] = 12'h123;
    res_w[1] = 12'h0AB;
    load_frame(1'b0);
    chk("word0", InputDataPort[11:0], 12'h001);
    chk("word14", InputDataPort[179:168], 12'h00F);
    start_seq();
    run_pulse(5);
    unload(0, 1'b0, OUTD);

    // Frame 2: 5-cycle consumer stall on the first word
    rand_frame();
    load_frame(1'b0);
    start_seq();
    run_pulse(3);
    unload(5, 1'b0, OUTD + 5);

    // Frame 3: finish high before RUN; only the edge at RUN cycle 20 captures
    rand_frame();
    rand_result();
    finish = 1'b1;
    load_frame(1'b1);
    start_seq();
    OutputDataPort = ~model_result();
    for (int j = 0; j <= 20; j++) begin
      chk("held_dv", data_valid, 1);
      chk("held_no_out", out_valid, 0);
      if (j == 0)  finish = 1'b1;
      if (j == 10) finish = 1'b0;
      if (j == 20) begin
        OutputDataPort = model_result();
        finish = 1'b1;
      end
      tick();
    end
    finish = 1'b0;
    OutputDataPort = ~model_result();
    unload(0, 1'b1, 0);

    // Frame 4: finish never asserted, timeout after TOC RUN cycles
    rand_frame();
    load_frame(1'b0);
    start_seq();
    for (int j = 0; j < TOC; j++) begin
      chk("to_run_dv", data_valid, 1);
      chk("to_run_no_out", out_valid, 0);
      chk("to_run_err", err, 0);
      tick();
    end
    chk("to_dv", data_valid, 0);
    chk("to_err", err, 1);
    chk("to_out_valid", out_valid, 0);
    chk("to_in_ready", in_ready, 1);
    chk("to_busy", busy, 0);
    repeat (3) begin
      chk("to_quiet", out_valid, 0);
      tick();
    end

    // Frame 5: normal frame after timeout, err stays set
    rand_frame();
    rand_result();
    load_frame(1'b1);
    start_seq();
    run_pulse($urandom_range(1, 40));
    unload(0, 1'b1, 0);
    chk("err_sticky", err, 1);

    // Reset after 7 words, then a fresh 15-word frame
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = BL'($urandom);
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_in_ready", in_ready, 0);
    chk("mid_input_port", InputDataPort, 0);
    chk("mid_err", err, 0);
    chk("mid_busy", busy, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rel_in_ready", in_ready, 1);
    rand_frame();
    rand_result();
    load_frame(1'b0);
    start_seq();
    run_pulse($urandom_range(1, 40));
    unload(0, 1'b0, OUTD);

    // Randomized frames
    for (int n = 0; n < 4; n++) begin
      rand_frame();
      rand_result();
      load_frame(1'b1);
      start_seq();
      run_pulse($urandom_range(1, 50));
      unload($urandom_range(0, 3), 1'b1, 0);
    end
    chk("final_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
